// File: rtl/cmd_loader_if.sv
// Host-to-loader bus: word stream in, command-memory write port and load status out.
// The master side is the host or testbench. The slave side is cmd_loader.
interface cmd_loader_if #(
  parameter int CMD_WIDTH      = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int CMD_ADDR_WIDTH = 8
);
  logic                      start;
  logic [CMD_ADDR_WIDTH-1:0] base_addr;
  logic [CMD_ADDR_WIDTH:0]   num_cmds;
  logic [WORD_WIDTH-1:0]     word_in;
  logic                      word_valid;
  logic                      word_ready;
  logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr;
  logic [CMD_WIDTH-1:0]      cmd_write;
  logic                      cmd_write_enable;
  logic                      busy;
  logic                      done;
  logic                      proc_reset;
  logic [WORD_WIDTH-1:0]     checksum;

  modport master (
    output start, base_addr, num_cmds, word_in, word_valid,
    input  word_ready, cmd_write_addr, cmd_write, cmd_write_enable,
           busy, done, proc_reset, checksum
  );

  modport slave (
    input  start, base_addr, num_cmds, word_in, word_valid,
    output word_ready, cmd_write_addr, cmd_write, cmd_write_enable,
           busy, done, proc_reset, checksum
  );
endinterface

// File: rtl/cmd_loader.sv
// Packs streamed words into commands and writes them to sequential command-memory addresses.
// Defining CMD_LOADER_CHECKSUM_EN adds a running XOR of the accepted words.
module cmd_loader #(
  parameter int CMD_WIDTH      = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_CMD  = 4,
  parameter int CMD_ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  cmd_loader_if.slave bus
);
  localparam int IDX_W = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_CMD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                    state_reg;
  logic [CMD_ADDR_WIDTH-1:0] addr_reg;
  logic [CMD_ADDR_WIDTH:0]   remaining_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [CMD_WIDTH-1:0]      pack_reg;
  logic [CMD_WIDTH-1:0]      pack_next;
  logic [CMD_WIDTH-1:0]      cmd_write_reg;
  logic                      wen_reg;
  logic                      done_reg;
  logic                      accept;
  logic                      start_ok;
  logic                      last_word;

  assign accept    = bus.word_valid && (state_reg == LOAD);
  assign start_ok  = bus.start && (state_reg != LOAD);
  assign last_word = accept && (idx_reg == LAST_IDX);

  // pack_next is the command including the word accepted this cycle.
  // The write register captures the complete command on the last word.
  for (genvar gi = 0; gi < WORDS_PER_CMD; gi++) begin : g_lane
    assign pack_next[gi*WORD_WIDTH +: WORD_WIDTH] =
      (accept && (idx_reg == IDX_W'(gi))) ? bus.word_in
                                          : pack_reg[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      idx_reg       <= '0;
      pack_reg      <= '0;
      cmd_write_reg <= '0;
      wen_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      wen_reg <= 1'b0;
      // Advance after each strobe. A newly latched base address overrides this below.
      if (wen_reg) begin
        addr_reg <= addr_reg + CMD_ADDR_WIDTH'(1);
      end
      case (state_reg)
        LOAD: begin
          if (accept) begin
            pack_reg <= pack_next;
            idx_reg  <= last_word ? '0 : idx_reg + IDX_W'(1);
          end
          if (last_word) begin
            cmd_write_reg <= pack_next;
            wen_reg       <= 1'b1;
            remaining_reg <= remaining_reg - (CMD_ADDR_WIDTH + 1)'(1);
            if (remaining_reg == (CMD_ADDR_WIDTH + 1)'(1)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: begin
          if (start_ok) begin
            if (bus.num_cmds == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg     <= LOAD;
              done_reg      <= 1'b0;
              addr_reg      <= bus.base_addr;
              remaining_reg <= bus.num_cmds;
              idx_reg       <= '0;
            end
          end
        end
      endcase
    end
  end

`ifdef CMD_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_reg <= '0;
    end else if (start_ok) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= checksum_reg ^ bus.word_in;
    end
  end

  assign bus.checksum = checksum_reg;
`else
  assign bus.checksum = '0;
`endif

  assign bus.word_ready       = (state_reg == LOAD);
  assign bus.busy             = (state_reg == LOAD);
  assign bus.proc_reset       = reset || (state_reg == LOAD);
  assign bus.cmd_write_addr   = addr_reg;
  assign bus.cmd_write        = cmd_write_reg;
  assign bus.cmd_write_enable = wen_reg;
  assign bus.done             = done_reg;
endmodule

// File: doc/cmd_loader.md
# cmd_loader

Host-side command loader directly upstream of the processor core's simulation toplevel. Accepts a stream of 32-bit words over a valid/ready handshake, packs every four consecutive words into one 128-bit command, and drives the toplevel's command-memory write port (cmd_write_addr / cmd_write / cmd_write_enable) with auto-incrementing addresses. It also holds the processor in reset for the duration of a load.

## Interface
Parameters:
- CMD_WIDTH, 128, packed command width; must equal WORD_WIDTH*WORDS_PER_CMD
- WORD_WIDTH, 32, input word width
- WORDS_PER_CMD, 4, words per command
- CMD_ADDR_WIDTH, 8, command memory address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load
- base_addr  in  CMD_ADDR_WIDTH  first command address, sampled on accepted start
- num_cmds  in  CMD_ADDR_WIDTH+1  number of commands to load, sampled on accepted start
- word_in  in  WORD_WIDTH  input data word
- word_valid  in  1  word_in valid
- word_ready  out  1  loader accepts a word this cycle
- cmd_write_addr  out  CMD_ADDR_WIDTH  command memory write address
- cmd_write  out  CMD_WIDTH  packed command
- cmd_write_enable  out  1  one-cycle write strobe
- busy  out  1  load in progress
- done  out  1  level, high after a load completes, until next accepted start
- proc_reset  out  1  reset request to the processor; high while busy or reset
- checksum  out  WORD_WIDTH  running XOR of accepted words (see Configuration)

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- start is accepted in IDLE or DONE only; ignored in LOAD.
- Accepted start with num_cmds == 0: -> DONE next cycle, no writes.
- Accepted start with num_cmds > 0: latch base_addr into write-address counter, num_cmds into remaining counter, clear word index and checksum, clear done -> LOAD.
- word_ready = (state == LOAD). Word accepted when word_valid && word_ready.
- Packing: k-th accepted word of a command (k = 0..3) is stored to bits [32k+31:32k]; word 0 is the LSB chunk.
- On acceptance of word 3: packed command is copied to the cmd_write output register, cmd_write_enable asserted, word index wraps to 0, remaining decrements.
- After each write strobe, cmd_write_addr increments by 1 modulo 2^CMD_ADDR_WIDTH (wrap from all-ones to 0 is legal, no error).
- When the write for the last command issues: word_ready drops, -> DONE; done asserts.
- busy = (state == LOAD). proc_reset = reset || busy.
- reset in any state, including mid-command: -> IDLE, partial words discarded, no write issued.

## Timing
- Reset values: word_ready 0, cmd_write_addr 0, cmd_write 0, cmd_write_enable 0, busy 0, done 0, proc_reset 1 (during reset), checksum 0.
- start at edge t -> busy and word_ready high from t+1.
- Fourth word accepted at edge t -> cmd_write_enable high for exactly cycle t+1 with cmd_write and cmd_write_addr valid in that cycle; cmd_write_addr advances at edge t+1.
- word_ready stays high during a write cycle (except after the last word), so sustained throughput is one word per cycle, one write every 4 cycles.
- Last word accepted at edge t -> word_ready low, busy low and done high from t+1, coincident with final write strobe; proc_reset deasserts at t+1.
- word_valid low stalls without penalty; word_in ignored when not accepted.
- cmd_write holds its last value between strobes.

## Configuration
- CMD_LOADER_CHECKSUM_EN defined: checksum holds the XOR of all words accepted since the last accepted start, updated the cycle after each acceptance; stable once done asserts.
- Not defined: checksum is tied to 0; no checksum logic is built. All other behaviour identical.

## Test plan
- Reset, then start with base_addr 0x10, num_cmds 1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> single strobe at addr 0x10, cmd_write 0x44444444_33333333_22222222_11111111, done high, busy low.
- num_cmds 3, base_addr 0xFE, continuous valid -> strobes at 0xFE, 0xFF, 0x00, spaced 4 cycles, done in cycle of third strobe.
- Random word_valid gaps over 2 commands -> identical cmd_write contents as gapless run, exactly 2 strobes.
- start during LOAD and with num_cmds 0 -> first ignored; second gives done next cycle, no strobe.
- reset asserted after 2 words of a command -> no strobe, IDLE, proc_reset high during reset; new load afterward starts at word index 0.
- With CMD_LOADER_CHECKSUM_EN, words 0x1, 0x2, 0x4, 0x8 -> checksum 0x0000000F; without macro -> checksum 0.
